cordic_scheduler: RTL

Shares one pipelined CORDIC sin/cos core among `N_REQ` requesters (NCO channels, modulators) with a round-robin valid/ready front end, at up to one angle per clock. The block folds each 16-bit turn-scaled angle into the first quadrant before it reaches the core. It carries quadrant and requester ID alongside the core pipeline, then sign-corrects and tags each result on return. It sits between the requesters and the core, and is the only driver of the core's angle input.

---
 rtl/cordic_pkg.sv | 49 ++++
 rtl/cordic_rr_arbiter.sv | 53 +++++
 rtl/cordic_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, tag type and angle fold/unfold helpers for the CORDIC scheduler.
package cordic_pkg;

   localparam logic [16:0] ANGLE_90  = 17'd16384;
   localparam logic [16:0] ANGLE_180 = 17'd32768;
   localparam logic [16:0] ANGLE_360 = 17'd65536;
   localparam int          TAG_ID_W  = 4;

   typedef logic [1:0] quadrant_t;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
      quadrant_t           q;
   } tag_t;

   // Map a full-turn angle onto 0..90 degrees; worked in 17 bits so 65536-theta is exact.
   function automatic logic [15:0] fold_angle(input logic [15:0] theta);
      logic [16:0] ext_s;
      logic [16:0] res_s;
      ext_s = {1'b0, theta};
      case (quadrant_t'(theta[15:14]))
         2'd0:    res_s = ext_s;
         2'd1:    res_s = ANGLE_180 - ext_s;
         2'd2:    res_s = ext_s - ANGLE_180;
         2'd3:    res_s = ANGLE_360 - ext_s;
         default: res_s = 17'd0;
      endcase
      return res_s[15:0];
   endfunction

   // Restore the signs of a first-quadrant sin/cos pair; returns {sin, cos}.
   function automatic logic [31:0] unfold_result(input quadrant_t q,
                                                 input logic [15:0] s,
                                                 input logic [15:0] c);
      logic [15:0] ns_s;
      logic [15:0] nc_s;
      ns_s = ~s + 16'd1;
      nc_s = ~c + 16'd1;
      case (q)
         2'd0:    return {s, c};
         2'd1:    return {s, nc_s};
         2'd2:    return {ns_s, nc_s};
         2'd3:    return {ns_s, c};
         default: return {s, c};
      endcase
   endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// N-way round-robin arbiter: searches from last+1, pointer moves only on a grant.
module cordic_rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     valid,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_any
);

   logic [IDX_W-1:0] last_r;
   logic [IDX_W:0]   sum_s;
   logic [IDX_W-1:0] cand_s;

   // Pick the first valid requester after last, wrapping modulo N.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      sum_s     = '0;
      cand_s    = '0;
      for (int k = 1; k <= N; k++) begin
         sum_s = {1'b0, last_r} + (IDX_W+1)'(k);
         if (sum_s >= (IDX_W+1)'(N)) begin
            cand_s = IDX_W'(sum_s - (IDX_W+1)'(N));
         end else begin
            cand_s = IDX_W'(sum_s);
         end
         if (!grant_any && valid[cand_s]) begin
            grant[cand_s] = 1'b1;
            grant_idx     = cand_s;
            grant_any     = 1'b1;
         end else begin
            grant_any = grant_any;
         end
      end
   end

   // Remember the most recently served requester; N-1 after reset gives requester 0 priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_r <= IDX_W'(N - 1);
      end else if (grant_any) begin
         last_r <= grant_idx;
      end else begin
         last_r <= last_r;
      end
   end

endmodule

// File: rtl/cordic_scheduler.sv
// Round-robin front end sharing one pipelined CORDIC core; folds angles in, unfolds results out.
// Optional per-requester grant counters are enabled with CORDIC_SCHED_STATS_EN.
module cordic_scheduler
   import cordic_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int LAT   = 13,
   parameter int W     = 16,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef CORDIC_SCHED_STATS_EN
   input  logic [IDX_W-1:0]     stat_sel,
   output logic [31:0]          stat_grants,
`endif
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [N_REQ*W-1:0]   req_theta,
   output logic [N_REQ-1:0]     req_ready,
   output logic [W-1:0]         cordic_theta,
   input  logic [W-1:0]         cordic_sin,
   input  logic [W-1:0]         cordic_cos,
   output logic                 res_valid,
   output logic [IDX_W-1:0]     res_id,
   output logic [W-1:0]         res_sin,
   output logic [W-1:0]         res_cos,
   output logic                 busy
);

   logic [N_REQ-1:0] grant_s;
   logic [IDX_W-1:0] grant_idx_s;
   logic             accept_s;
   logic [W-1:0]     sel_theta_s;
   tag_t             new_tag_s;
   tag_t             tag_r [0:LAT];
   logic [31:0]      unf_s;
   logic             id_unused_s;

   cordic_rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .valid     (req_valid),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .grant_any (accept_s)
   );

   assign req_ready   = grant_s;
   assign id_unused_s = ^tag_r[LAT].id;

   // Select the granted angle and build the tag that travels beside the core.
   always_comb begin
      sel_theta_s = req_theta[grant_idx_s*W +: W];
      if (accept_s) begin
         new_tag_s = '{valid: 1'b1, id: TAG_ID_W'(grant_idx_s), q: sel_theta_s[15:14]};
      end else begin
         new_tag_s = '0;
      end
   end

   // Drive the core with the folded angle, or zero when nothing is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         cordic_theta <= '0;
      end else if (accept_s) begin
         cordic_theta <= fold_angle(sel_theta_s);
      end else begin
         cordic_theta <= '0;
      end
   end

   // Free-running tag shift register aligned with the core latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= LAT; k++) begin
            tag_r[k] <= '0;
         end
      end else begin
         tag_r[0] <= new_tag_s;
         for (int k = 1; k <= LAT; k++) begin
            tag_r[k] <= tag_r[k-1];
         end
      end
   end

   // Sign-correct the core output using the quadrant carried in the last tag.
   always_comb begin
      unf_s = unfold_result(tag_r[LAT].q, cordic_sin, cordic_cos);
   end

   // Register tagged results; data holds between strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_id    <= '0;
         res_sin   <= '0;
         res_cos   <= '0;
      end else if (tag_r[LAT].valid) begin
         res_valid <= 1'b1;
         res_id    <= tag_r[LAT].id[IDX_W-1:0];
         res_sin   <= unf_s[31:16];
         res_cos   <= unf_s[15:0];
      end else begin
         res_valid <= 1'b0;
         res_id    <= res_id;
         res_sin   <= res_sin;
         res_cos   <= res_cos;
      end
   end

   // Busy while any tag stage still holds an issued angle.
   always_comb begin
      busy = 1'b0;
      for (int k = 0; k <= LAT; k++) begin
         busy = busy | tag_r[k].valid;
      end
   end

`ifdef CORDIC_SCHED_STATS_EN
   logic [31:0] cnt_r [N_REQ];

   // Saturating acceptance counters, one per requester.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            cnt_r[i] <= 32'd0;
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (accept_s && (32'(grant_idx_s) == i) && (cnt_r[i] != 32'hFFFF_FFFF)) begin
               cnt_r[i] <= cnt_r[i] + 32'd1;
            end else begin
               cnt_r[i] <= cnt_r[i];
            end
         end
      end
   end

   // Registered read-out of the selected counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_grants <= 32'd0;
      end else if (32'(stat_sel) < N_REQ) begin
         stat_grants <= cnt_r[stat_sel];
      end else begin
         stat_grants <= 32'd0;
      end
   end
`endif

endmodule
